mdu_ctrl: RTL and testbench

//  Sequencer for the HI/LO multiply-divide resource in the E stage of the P7 pipeline.
//  - Consumes the 4-bit HILO_type code decoded for the E-stage instruction and its rs/rt operands.
//  - Starts mult/multu/div/divu, holds busy for a fixed latency, then commits the result to HI/LO.
//  - Serves mfhi/mflo/mthi/mtlo.
//  - Raises a D-stage stall while the unit is occupied.

---
 rtl/mdu_ctrl_pkg.sv | 27 ++
 rtl/mdu_arith.sv | 61 ++++++
 rtl/mdu_ctrl.sv | 101 ++++++++++
 tb/tb_mdu_ctrl.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared HILO op encodings and helpers for the E-stage multiply/divide sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdu_ctrl_pkg;

    // 4-bit HILO_type code decoded for the E-stage instruction.
    // Bit 0 selects divide, bit 1 selects unsigned, for the four md ops.
    typedef enum logic [3:0] {
        HILO_MULT  = 4'b0000,
        HILO_DIV   = 4'b0001,
        HILO_MULTU = 4'b0010,
        HILO_DIVU  = 4'b0011,
        HILO_MFHI  = 4'b0100,
        HILO_MFLO  = 4'b0101,
        HILO_MTHI  = 4'b0110,
        HILO_MTLO  = 4'b0111,
        HILO_NONE  = 4'b1000
    } hilo_type_e;

    localparam int HILO_W = 4;

    // True for mult/multu/div/divu, the ops that occupy the unit.
    function automatic logic is_md_op(input logic [HILO_W-1:0] code);
        return (code[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply and divide, signed or unsigned, producing {HI,LO}.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; result follows the inputs.
//
// Ports:
//   op[1:0]   bit0: 1=divide 0=multiply; bit1: 1=unsigned 0=signed
//   rs, rt    operands (rs = multiplicand / dividend, rt = multiplier / divisor)
//   res_hi    product[63:32] or remainder
//   res_lo    product[31:0]  or quotient
//   div_zero  divide with rt==0; res_* are then meaningless and must be ignored
module mdu_arith (
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic        is_div;
    logic        is_uns;
    logic [63:0] ext_rs;
    logic [63:0] ext_rt;
    logic [63:0] prod;

    logic        neg_rs;
    logic        neg_rt;
    logic [31:0] mag_rs;
    logic [31:0] mag_rt;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] quo;
    logic [31:0] rem;

    assign is_div = op[0];
    assign is_uns = op[1];

    // Low 64 bits of the product of the 64-bit extended operands equal the
    // signed or unsigned 32x32 product, so one multiplier serves both.
    assign ext_rs = is_uns ? {32'b0, rs} : {{32{rs[31]}}, rs};
    assign ext_rt = is_uns ? {32'b0, rt} : {{32{rt[31]}}, rt};
    assign prod   = ext_rs * ext_rt;

    // Signed divide runs on magnitudes. -2^31 has magnitude 0x80000000 as an
    // unsigned value, so -2^31 / -1 yields quotient 0x80000000, remainder 0
    // without a special case. A zero divisor is replaced by 1 to keep the
    // divider defined; the caller discards the result via div_zero.
    assign neg_rs = ~is_uns & rs[31];
    assign neg_rt = ~is_uns & rt[31];
    assign mag_rs = neg_rs ? (~rs + 32'd1) : rs;
    assign mag_rt = (rt == 32'd0) ? 32'd1 : (neg_rt ? (~rt + 32'd1) : rt);
    assign mag_q  = mag_rs / mag_rt;
    assign mag_r  = mag_rs % mag_rt;
    assign quo    = (neg_rs ^ neg_rt) ? (~mag_q + 32'd1) : mag_q;
    assign rem    = neg_rs ? (~mag_r + 32'd1) : mag_r;   // sign of dividend

    assign res_hi   = is_div ? rem : prod[63:32];
    assign res_lo   = is_div ? quo : prod[31:0];
    assign div_zero = is_div & (rt == 32'd0);

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage HI/LO sequencer: starts mult/div, holds busy for a fixed latency, commits HI/LO, serves mf/mt.
// Latency: MULT_CYCLES or DIV_CYCLES busy cycles after the start cycle; mf reads are combinational.
// Backpressure: md_stall holds a HILO-using D-stage instruction while an op starts or is in flight.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   hilo_type           E-stage op code (see mdu_ctrl_pkg::hilo_type_e)
//   rs_val, rt_val      forwarded E-stage operands
//   e_cancel            E instruction flushed: suppresses start and mt writes
//   d_uses_md           D-stage instruction touches HI/LO
//   start, busy         op issuing this cycle / op in flight
//   md_stall            D-stage stall request
//   mf_out              HI for mfhi, LO for mflo, else 0
//   hi_q, lo_q          architectural HI/LO
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  hilo_type,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        e_cancel,
    input  logic        d_uses_md,
    output logic        start,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] mf_out,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;

    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             div_zero;

    mdu_arith u_arith (
        .op       (hilo_type[1:0]),
        .rs       (rs_val),
        .rt       (rt_val),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    // IDLE is cnt==0, RUN is cnt!=0; the count itself is the state.
    assign busy     = (cnt != '0);
    assign start    = is_md_op(hilo_type) & ~e_cancel & ~busy;
    assign md_stall = d_uses_md & (start | busy);

    always_comb begin
        mf_out = 32'd0;
        case (hilo_type)
            HILO_MFHI: mf_out = hi_q;
            HILO_MFLO: mf_out = lo_q;
            default:   mf_out = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else begin
            if (~e_cancel) begin
                if (hilo_type == HILO_MTHI) hi_q <= rs_val;
                if (hilo_type == HILO_MTLO) lo_q <= rs_val;
            end

            // Commit is placed after the mt writes so a stray mt during RUN
            // is overwritten by the pending result. e_cancel never aborts RUN:
            // the running op is older than the flushed instruction.
            if (busy) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    hi_q <= pend_hi;
                    lo_q <= pend_lo;
                end
            end else if (start) begin
                cnt <= hilo_type[0] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                // Divide by zero recommits the current HI/LO, leaving them unchanged.
                pend_hi <= div_zero ? hi_q : res_hi;
                pend_lo <= div_zero ? lo_q : res_lo;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  hilo_type;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        e_cancel;
    logic        d_uses_md;
    logic        start;
    logic        busy;
    logic        md_stall;
    logic [31:0] mf_out;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .hilo_type (hilo_type),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .e_cancel  (e_cancel),
        .d_uses_md (d_uses_md),
        .start     (start),
        .busy      (busy),
        .md_stall  (md_stall),
        .mf_out    (mf_out),
        .hi_q      (hi_q),
        .lo_q      (lo_q)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    int    errors = 0;
    int    checks = 0;
    hilo_t sb[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    // Reference arithmetic, written directly from the instruction semantics.
    function automatic hilo_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] cur_hi, input logic [31:0] cur_lo);
        hilo_t       r;
        longint      sp;
        logic [63:0] up;
        r.hi = cur_hi;
        r.lo = cur_lo;
        case (op)
            HILO_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                r.hi = sp[63:32];
                r.lo = sp[31:0];
            end
            HILO_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                r.hi = up[63:32];
                r.lo = up[31:0];
            end
            HILO_DIV: begin
                if (b == 32'd0) begin
                    r.hi = cur_hi;
                    r.lo = cur_lo;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.hi = 32'd0;
                    r.lo = 32'h8000_0000;
                end else begin
                    r.lo = $signed(a) / $signed(b);
                    r.hi = $signed(a) % $signed(b);
                end
            end
            HILO_DIVU: begin
                if (b != 32'd0) begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
            default: ;
        endcase
        return r;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives an md op for one cycle, records start, pushes the expected commit.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic st);
        hilo_type = op;
        rs_val    = a;
        rt_val    = b;
        #2;
        st = start;
        sb.push_back(model(op, a, b, m_hi, m_lo));
        step();
        hilo_type = HILO_NONE;
    endtask

    // Counts busy cycles until busy drops, bounded so a stuck DUT cannot hang the run.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
    endtask

    // Compares HI/LO against the oldest scoreboard entry in the first idle cycle.
    task automatic commit_check(input string name);
        hilo_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty at commit", name);
        end else begin
            e = sb.pop_front();
            if (hi_q !== e.hi || lo_q !== e.lo) begin
                errors++;
                $display("FAIL %s: hi/lo=%h/%h expected %h/%h", name, hi_q, lo_q, e.hi, e.lo);
            end
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0 || hi_q !== 32'd0 || lo_q !== 32'd0 || start !== 1'b0 || mf_out !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%b hi=%h lo=%h start=%b mf=%h expected 0", busy, hi_q, lo_q, start, mf_out);
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
        step();
    endtask

    task automatic test_mult();
        logic st;
        int   n;
        issue(HILO_MULT, 32'hFFFF_FFFE, 32'd3, st);
        #2;
        checks++;
        if (st !== 1'b1 || start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mult_start: start0=%b start1=%b busy=%b expected 1/0/1", st, start, busy);
        end
        wait_idle(n);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL mult_latency: busy %0d cycles expected 5", n);
        end
        checks++;
        if (hi_q !== 32'hFFFF_FFFF || lo_q !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL mult_const: hi/lo=%h/%h expected ffffffff/fffffffa", hi_q, lo_q);
        end
        commit_check("mult");
        issue(HILO_MULTU, 32'hFFFF_FFFE, 32'd3, st);
        wait_idle(n);
        commit_check("multu");
    endtask

    task automatic test_div();
        logic st;
        int   n;
        issue(HILO_DIVU, 32'd100, 32'd7, st);
        wait_idle(n);
        checks++;
        if (n != 10 || st !== 1'b1) begin
            errors++;
            $display("FAIL divu_latency: busy %0d cycles start=%b expected 10 and 1", n, st);
        end
        checks++;
        if (lo_q !== 32'd14 || hi_q !== 32'd2) begin
            errors++;
            $display("FAIL divu_const: hi/lo=%h/%h expected 2/14", hi_q, lo_q);
        end
        commit_check("divu");
        issue(HILO_DIV, 32'hFFFF_FFF9, 32'd2, st);
        wait_idle(n);
        checks++;
        if (lo_q !== 32'hFFFF_FFFD || hi_q !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_neg: hi/lo=%h/%h expected ffffffff/fffffffd", hi_q, lo_q);
        end
        commit_check("div_neg");
        // Random mix of all four md ops.
        for (int i = 0; i < 8; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 3));
            issue(op, $urandom, (i == 3) ? 32'hFFFF_FFF3 : $urandom, st);
            wait_idle(n);
            checks++;
            if (n != (op[0] ? 10 : 5)) begin
                errors++;
                $display("FAIL rand_latency: op=%0d busy %0d cycles", op, n);
            end
            commit_check("rand_op");
        end
    endtask

    task automatic test_div_edge();
        logic st;
        int   n;
        issue(HILO_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st);
        wait_idle(n);
        checks++;
        if (lo_q !== 32'h8000_0000 || hi_q !== 32'd0) begin
            errors++;
            $display("FAIL div_ovf: hi/lo=%h/%h expected 0/80000000", hi_q, lo_q);
        end
        commit_check("div_ovf");
        hilo_type = HILO_MTHI;
        rs_val    = 32'h11;
        step();
        hilo_type = HILO_MTLO;
        rs_val    = 32'h22;
        step();
        hilo_type = HILO_NONE;
        m_hi = 32'h11;
        m_lo = 32'h22;
        issue(HILO_DIV, 32'd1234, 32'd0, st);
        wait_idle(n);
        checks++;
        if (n != 10 || hi_q !== 32'h11 || lo_q !== 32'h22) begin
            errors++;
            $display("FAIL div_zero: cycles=%0d hi/lo=%h/%h expected 10 and 11/22", n, hi_q, lo_q);
        end
        commit_check("div_zero");
        issue(HILO_DIVU, 32'd99, 32'd0, st);
        wait_idle(n);
        commit_check("divu_zero");
    endtask

    task automatic test_stall();
        logic st;
        int   n;
        int   bad;
        d_uses_md = 1'b1;
        hilo_type = HILO_MULTU;
        rs_val    = 32'h0001_0000;
        rt_val    = 32'h0003_0000;
        #2;
        checks++;
        if (md_stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_start: md_stall=%b expected 1", md_stall);
        end
        hilo_type = HILO_NONE;
        #0;
        hilo_type = HILO_MULTU;
        issue(HILO_MULTU, 32'h0001_0000, 32'h0003_0000, st);
        n   = 0;
        bad = 0;
        while (busy === 1'b1 && n < 100) begin
            #2;
            if (md_stall !== 1'b1) bad++;
            n++;
            step();
        end
        checks++;
        if (bad != 0 || n != 5) begin
            errors++;
            $display("FAIL stall_busy: %0d busy cycles without stall, %0d cycles, expected 0 and 5", bad, n);
        end
        #2;
        checks++;
        if (md_stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: md_stall=%b expected 0", md_stall);
        end
        commit_check("stall_multu");
        hilo_type = HILO_MFHI;
        #1;
        checks++;
        if (mf_out !== m_hi) begin
            errors++;
            $display("FAIL mfhi: mf_out=%h expected %h", mf_out, m_hi);
        end
        hilo_type = HILO_MFLO;
        #1;
        checks++;
        if (mf_out !== m_lo) begin
            errors++;
            $display("FAIL mflo: mf_out=%h expected %h", mf_out, m_lo);
        end
        hilo_type = HILO_NONE;
        d_uses_md = 1'b0;
        step();
    endtask

    task automatic test_cancel();
        e_cancel  = 1'b1;
        hilo_type = HILO_MULT;
        rs_val    = 32'd7;
        rt_val    = 32'd9;
        #2;
        checks++;
        if (start !== 1'b0) begin
            errors++;
            $display("FAIL cancel_start: start=%b expected 0", start);
        end
        step();
        hilo_type = HILO_MTHI;
        rs_val    = 32'h0000_ABCD;
        step();
        hilo_type = HILO_NONE;
        #2;
        checks++;
        if (busy !== 1'b0 || hi_q !== m_hi || lo_q !== m_lo) begin
            errors++;
            $display("FAIL cancel_hold: busy=%b hi/lo=%h/%h expected 0 and %h/%h", busy, hi_q, lo_q, m_hi, m_lo);
        end
        e_cancel  = 1'b0;
        step();
        hilo_type = HILO_MTHI;
        rs_val    = 32'h0000_ABCD;
        step();
        hilo_type = HILO_NONE;
        m_hi      = 32'h0000_ABCD;
        #2;
        checks++;
        if (hi_q !== 32'h0000_ABCD || lo_q !== m_lo) begin
            errors++;
            $display("FAIL mthi: hi/lo=%h/%h expected 0000abcd/%h", hi_q, lo_q, m_lo);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic st;
        int   n;
        issue(HILO_MULT, 32'd1000, 32'hFFFF_FFFF, st);
        // A second md op arriving while busy must be ignored.
        hilo_type = HILO_DIVU;
        rs_val    = 32'd50;
        rt_val    = 32'd5;
        #2;
        checks++;
        if (start !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ignore: start=%b expected 0", start);
        end
        step();
        hilo_type = HILO_NONE;
        wait_idle(n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL b2b_latency: remaining busy %0d cycles expected 4", n);
        end
        commit_check("b2b_mult");
        issue(HILO_DIVU, 32'd50, 32'd5, st);
        wait_idle(n);
        commit_check("b2b_divu");
    endtask

    task automatic test_reset_mid();
        logic st;
        int   bad;
        issue(HILO_DIV, 32'd50, 32'd3, st);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        void'(sb.pop_back());
        m_hi = 32'd0;
        m_lo = 32'd0;
        #2;
        checks++;
        if (busy !== 1'b0 || hi_q !== 32'd0 || lo_q !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b hi/lo=%h/%h expected 0 and 0/0", busy, hi_q, lo_q);
        end
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (busy !== 1'b0 || hi_q !== 32'd0 || lo_q !== 32'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_no_commit: %0d cycles with busy or nonzero hi/lo, expected 0", bad);
        end
    endtask

    initial begin
        reset     = 1'b1;
        hilo_type = HILO_NONE;
        rs_val    = 32'd0;
        rt_val    = 32'd0;
        e_cancel  = 1'b0;
        d_uses_md = 1'b0;
        m_hi      = 32'd0;
        m_lo      = 32'd0;
        #1;
        test_reset();
        test_mult();
        test_div();
        test_div_edge();
        test_stall();
        test_cancel();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
